sample_playback: RTL and testbench
==================================

Name: sample_playback

Overview:
- Output-direction counterpart of the capture path: the Nios CPU pushes 16-bit samples through PIO outputs, and this block buffers them in an internal synchronous FIFO.
- It drains one sample per sample tick, from a built-in clock divider, to a downstream sink (DAC/GPIO driver).
- It reports fill level, full, underrun and overflow back to the CPU through PIO inputs.
- Sits in the top level beside the Qsys system, clocked from CLOCK_50.

Parameters:
- DIV, 50, clk cycles per sample tick; must be >= 2.
- DEPTH, 256, FIFO words; power of two, >= 4.
- PRIME_LEVEL, 128, words required before playback starts or resumes; 1..DEPTH.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  playback enable (PIO bit).
- flush  in  1  level-sensitive; empties FIFO while high.
- clear  in  1  clears sticky flags while high.
- wr_data  in  16  sample from CPU PIO.
- wr_strobe  in  1  CPU write toggle; rising edge = one write.
- sample_out  out  16  current output sample.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- full  out  1  level == DEPTH.
- underrun  out  1  sticky: tick occurred in PLAY with FIFO empty.
- overflow  out  1  sticky: write dropped because FIFO full.
- playing  out  1  state == PLAY.

Behaviour:
- Reset values: all outputs 0; FIFO empty; divider 0; state IDLE; wr_strobe edge register 0.
- Write path:
  - wr_strobe is registered once; write_req = wr_strobe & ~wr_strobe_q. Strobe level held high produces exactly one write.
  - write_req is accepted if !full, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow sets.
- Divider:
  - Counts 0..DIV-1 only when state != IDLE; tick = (count == DIV-1).
  - Forced to 0 in IDLE.
- States:
  - IDLE: entered when enable=0, from any state, on the next clock. Exit to PRIME when enable=1.
  - PRIME: no pops. Go to PLAY when level >= PRIME_LEVEL (checked every cycle).
  - PLAY: on tick, pop head word. If empty at tick, no pop, underrun sets, go to STARVED.
  - STARVED: on tick, emit fill value (see Optional Feature). Go to PLAY when level >= PRIME_LEVEL.
- Output timing:
  - Tick at cycle N gives sample_out updated and sample_valid=1 at cycle N+1 (1-cycle latency).
  - sample_valid pulses on every tick in PLAY and STARVED, never in IDLE/PRIME.
- Simultaneous push and pop: both occur, level unchanged; write to a full FIFO with a same-cycle pop is accepted.
- Pointers: log2(DEPTH) bits wrap naturally; level is a separate counter, saturating 0..DEPTH.
- Flush: resets pointers/level the same cycle; a concurrent write is discarded without setting overflow. In PLAY, the next tick sees empty and causes underrun.
- Clear has priority over a same-cycle set of underrun/overflow (flag ends 0).
- IDLE does not alter sample_out or the FIFO contents.
- Async reset mid-operation: all state returns to reset values immediately; no sample_valid is produced.

Optional Feature:
- Macro PLAYBACK_HOLD_LAST_EN.
- Defined: the STARVED tick re-emits the last popped sample (0 if none since reset).
- Undefined: the STARVED tick emits 16'h0000.
- sample_valid pulses identically in both builds.

Decomposition:
- Package playback_pkg holds:
  - the state enum (IDLE, PRIME, PLAY, STARVED);
  - SAMPLE_W = 16;
  - the zero-fill constant.
- One sub-module, playback_fifo: synchronous FIFO with push/pop/flush, level, full, empty. Read data is registered on pop.
- The top holds the strobe edge detect, divider, FSM and flags.

Test Plan (DIV=4, DEPTH=8, PRIME_LEVEL=4):
- Reset, enable=1, write 0x0001..0x0004 -> PLAY after the 4th write. sample_valid every 4 clks, sample_out 1,2,3,4. Next tick: underrun=1, sample_out=0 (held 4 with PLAYBACK_HOLD_LAST_EN).
- Write 9 words with enable=0 -> level=8, full=1, overflow=1. Toggle clear -> overflow=0, level stays 8.
- Hold wr_strobe high 20 cycles -> exactly one write, level +1.
- In PLAY with level=8 and full, issue a write in the same cycle as a tick pop -> write accepted, level stays 8, overflow=0.
- In PLAY, assert flush -> level=0 next cycle; following tick sets underrun and enters STARVED. Write 4 words -> PLAY resumes.
- Assert reset_n=0 mid-PLAY -> outputs, level and state return to 0/IDLE immediately. No sample_valid until re-primed.

Source files
------------

// File: rtl/playback_pkg.sv
// Shared types and constants for the sample playback path.
package playback_pkg;

    localparam int SAMPLE_W = 16;
    localparam logic [SAMPLE_W-1:0] ZERO_FILL = '0;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        PLAY,
        STARVED
    } state_t;

endpackage

// File: rtl/playback_fifo.sv
// Synchronous sample FIFO with flush, occupancy counter and registered read data.
module playback_fifo
    import playback_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [SAMPLE_W-1:0]     wr_data,
    output logic [SAMPLE_W-1:0]     rd_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = PTR_W + 1;
    localparam logic [LEVEL_W-1:0] DEPTH_LV = LEVEL_W'(DEPTH);

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign full    = (level == DEPTH_LV);
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty & ~flush;
    // A same-cycle pop frees the slot, so a write to a full FIFO still lands.
    assign do_push = push & ~flush & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rd_data <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10: if (level != DEPTH_LV) level <= level + LEVEL_W'(1);
                2'b01: if (level != '0)       level <= level - LEVEL_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sample_playback.sv
// CPU-fed sample playback: strobe edge detect, tick divider, prime/play FSM, sticky flags.
// Optional macro PLAYBACK_HOLD_LAST_EN: starved ticks repeat the last popped sample instead of zero.
module sample_playback
    import playback_pkg::*;
#(
    parameter int DIV         = 50,
    parameter int DEPTH       = 256,
    parameter int PRIME_LEVEL = 128
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    flush,
    input  logic                    clear,
    input  logic [SAMPLE_W-1:0]     wr_data,
    input  logic                    wr_strobe,
    output logic [SAMPLE_W-1:0]     sample_out,
    output logic                    sample_valid,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    underrun,
    output logic                    overflow,
    output logic                    playing
);

    localparam int CNT_W   = $clog2(DIV);
    localparam int LEVEL_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]   DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [LEVEL_W-1:0] PRIME_LV = LEVEL_W'(PRIME_LEVEL);

    state_t              state;
    state_t              state_next;
    logic                wr_strobe_q;
    logic [CNT_W-1:0]    count;
    logic                tick;
    logic                in_play;
    logic                active;
    logic                primed;
    logic                write_req;
    logic                push;
    logic                pop;
    logic                drop;
    logic                starve_tick;
    logic                fifo_empty;
    logic [SAMPLE_W-1:0] fifo_rd;

    assign write_req   = wr_strobe & ~wr_strobe_q;
    assign tick        = (state != IDLE) && (count == DIV_LAST);
    assign primed      = (level >= PRIME_LV);
    assign pop         = tick & in_play & ~fifo_empty & ~flush;
    assign starve_tick = tick & in_play & (fifo_empty | flush);
    assign push        = write_req & ~flush & (~full | pop);
    assign drop        = write_req & ~flush & full & ~pop;

    playback_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (fifo_rd),
        .level   (level),
        .full    (full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = PRIME;
                PRIME:   if (primed) state_next = PLAY;
                PLAY:    if (starve_tick) state_next = STARVED;
                STARVED: if (primed) state_next = PLAY;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        in_play = (state == PLAY);
        active  = (state == PLAY) || (state == STARVED);
        playing = in_play;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count        <= '0;
            wr_strobe_q  <= 1'b0;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            wr_strobe_q  <= wr_strobe;
            sample_valid <= tick & active;
            if (state == IDLE || count == DIV_LAST) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
            if (clear) begin
                underrun <= 1'b0;
            end else if (starve_tick) begin
                underrun <= 1'b1;
            end
            if (clear) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef PLAYBACK_HOLD_LAST_EN
    // FIFO read register still holds the last popped word, which is exactly the hold value.
    assign sample_out = fifo_rd;
`else
    logic fill_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_sel <= 1'b0;
        end else if (tick && active) begin
            fill_sel <= ~pop;
        end
    end

    assign sample_out = fill_sel ? ZERO_FILL : fifo_rd;
`endif

endmodule

// File: tb/tb_sample_playback.sv
// Directed self-checking bench for sample_playback (DIV=4, DEPTH=8, PRIME_LEVEL=4).
module tb_sample_playback;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        flush;
    logic        clear;
    logic [15:0] wr_data;
    logic        wr_strobe;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic [3:0]  level;
    logic        full;
    logic        underrun;
    logic        overflow;
    logic        playing;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

`ifdef PLAYBACK_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    sample_playback #(
        .DIV         (4),
        .DEPTH       (8),
        .PRIME_LEVEL (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .flush        (flush),
        .clear        (clear),
        .wr_data      (wr_data),
        .wr_strobe    (wr_strobe),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .level        (level),
        .full         (full),
        .underrun     (underrun),
        .overflow     (overflow),
        .playing      (playing)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] d);
        wr_data   = d;
        wr_strobe = 1'b1;
        step();
        wr_strobe = 1'b0;
        step();
    endtask

    task automatic wait_valid(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (!ok) begin
                @(negedge clk);
                if (sample_valid) ok = 1'b1;
            end
        end
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: sample_valid not seen within 24 cycles", name);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; flush = 1'b0; clear = 1'b0;
        wr_data = '0; wr_strobe = 1'b0;
        #2;
        checks++;
        if ({sample_out, sample_valid, level, full, underrun, overflow, playing} !== 26'd0) begin
            fails++;
            $display("FAIL reset_outputs: got out=%h v=%b lvl=%0d f=%b u=%b o=%b p=%b required all 0",
                     sample_out, sample_valid, level, full, underrun, overflow, playing);
        end
        step(); step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_prime_play();
        int prev;
        enable = 1'b1;
        step();
        for (int i = 1; i <= 4; i++) do_write(16'(i));
        @(negedge clk);
        checks++;
        if (playing !== 1'b1) begin
            fails++; $display("FAIL prime_to_play: playing=%b required 1", playing);
        end
        prev = 0;
        for (int i = 1; i <= 4; i++) begin
            wait_valid("play_valid");
            checks++;
            if (sample_out !== 16'(i)) begin
                fails++; $display("FAIL play_sample%0d: got %h required %h", i, sample_out, 16'(i));
            end
            if (i > 1) begin
                checks++;
                if (cyc - prev !== 4) begin
                    fails++; $display("FAIL tick_period: got %0d required 4", cyc - prev);
                end
            end
            prev = cyc;
        end
        wait_valid("underrun_valid");
        checks++;
        if (underrun !== 1'b1 || playing !== 1'b0) begin
            fails++; $display("FAIL underrun_enter: underrun=%b playing=%b required 1 0", underrun, playing);
        end
        checks++;
        if (sample_out !== (HOLD ? 16'h0004 : 16'h0000)) begin
            fails++; $display("FAIL starve_fill: got %h required %h", sample_out, HOLD ? 16'h0004 : 16'h0000);
        end
    endtask

    task automatic test_overflow_clear();
        enable = 1'b0;
        clear  = 1'b1;
        step();
        clear = 1'b0;
        step();
        checks++;
        if (underrun !== 1'b0) begin
            fails++; $display("FAIL clear_underrun: got %b required 0", underrun);
        end
        for (int i = 0; i < 9; i++) do_write(16'(16'h0100 + i));
        @(negedge clk);
        checks++;
        if (level !== 4'd8 || full !== 1'b1 || overflow !== 1'b1) begin
            fails++; $display("FAIL overflow_set: lvl=%0d full=%b ovf=%b required 8 1 1", level, full, overflow);
        end
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0 || level !== 4'd8) begin
            fails++; $display("FAIL overflow_clear: ovf=%b lvl=%0d required 0 8", overflow, level);
        end
    endtask

    task automatic test_strobe_held();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (level !== 4'd0 || overflow !== 1'b0) begin
            fails++; $display("FAIL flush_idle: lvl=%0d ovf=%b required 0 0", level, overflow);
        end
        step();
        wr_data   = 16'h00AA;
        wr_strobe = 1'b1;
        for (int i = 0; i < 20; i++) step();
        wr_strobe = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (level !== 4'd1) begin
            fails++; $display("FAIL strobe_held: lvl=%0d required 1", level);
        end
    endtask

    task automatic test_push_pop_full();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 8; i++) do_write(16'(16'h0010 + i));
        enable = 1'b1;
        wait_valid("first_pop");
        checks++;
        if (sample_out !== 16'h0010 || level !== 4'd7) begin
            fails++; $display("FAIL first_pop: out=%h lvl=%0d required 0010 7", sample_out, level);
        end
        step();
        wr_data = 16'h0018; wr_strobe = 1'b1;
        step();
        wr_strobe = 1'b0;
        @(negedge clk);
        checks++;
        if (level !== 4'd8 || full !== 1'b1) begin
            fails++; $display("FAIL refill_full: lvl=%0d full=%b required 8 1", level, full);
        end
        step();
        wr_data = 16'h0019; wr_strobe = 1'b1;
        step();
        wr_strobe = 1'b0;
        @(negedge clk);
        checks++;
        if (sample_valid !== 1'b1 || sample_out !== 16'h0011) begin
            fails++; $display("FAIL push_pop_sample: v=%b out=%h required 1 0011", sample_valid, sample_out);
        end
        checks++;
        if (level !== 4'd8 || full !== 1'b1 || overflow !== 1'b0) begin
            fails++; $display("FAIL push_pop_full: lvl=%0d full=%b ovf=%b required 8 1 0", level, full, overflow);
        end
    endtask

    task automatic test_flush_play();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (level !== 4'd0 || overflow !== 1'b0) begin
            fails++; $display("FAIL flush_play: lvl=%0d ovf=%b required 0 0", level, overflow);
        end
        wait_valid("flush_underrun");
        checks++;
        if (underrun !== 1'b1 || playing !== 1'b0) begin
            fails++; $display("FAIL flush_underrun: underrun=%b playing=%b required 1 0", underrun, playing);
        end
        checks++;
        if (sample_out !== (HOLD ? 16'h0011 : 16'h0000)) begin
            fails++; $display("FAIL flush_fill: got %h required %h", sample_out, HOLD ? 16'h0011 : 16'h0000);
        end
        step();
        for (int i = 0; i < 4; i++) do_write(16'(16'h0020 + i));
        @(negedge clk);
        checks++;
        if (playing !== 1'b1) begin
            fails++; $display("FAIL resume_play: playing=%b required 1", playing);
        end
    endtask

    task automatic test_async_reset();
        int pulses;
        wait_valid("pre_reset_valid");
        reset_n = 1'b0;
        #1;
        checks++;
        if ({sample_out, sample_valid, level, full, underrun, overflow, playing} !== 26'd0) begin
            fails++;
            $display("FAIL async_reset: got out=%h v=%b lvl=%0d f=%b u=%b o=%b p=%b required all 0",
                     sample_out, sample_valid, level, full, underrun, overflow, playing);
        end
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sample_valid) pulses++;
        end
        checks++;
        if (pulses !== 0 || playing !== 1'b0) begin
            fails++; $display("FAIL post_reset_quiet: pulses=%0d playing=%b required 0 0", pulses, playing);
        end
    endtask

    initial begin
        test_reset();
        test_prime_play();
        test_overflow_clear();
        test_strobe_held();
        test_push_pop_full();
        test_flush_play();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
